ternary_mvm_seq: RTL and testbench

- Sequencer for the ternary matrix-vector multiply datapath (2-bit ternary weights, 8-bit signed activations, two activations per row step).
- Three jobs: load the packed weight matrix from a byte stream; issue activation pairs with the row index one row per cycle; drain the OutLen results through a valid/ready port.
- Sits between the chip I/O shim and the multiply datapath. Owns all row sequencing for the datapath.

---
 rtl/ternary_mvm_pkg.sv | 26 ++
 rtl/ternary_wbuf.sv | 61 ++++++
 rtl/ternary_mvm_seq.sv | 174 +++++++++++++++++
 tb/tb_ternary_mvm_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_mvm_pkg.sv
// Shared types and sizing for the ternary matrix-vector sequencer.
// Ternary weight code: 01 = +1, 11 = -1, 00/10 = 0.
package ternary_mvm_pkg;

    localparam int IN_LEN    = 14;
    localparam int OUT_LEN   = 7;
    localparam int BIT_WIDTH = 8;

    localparam int ROWS   = IN_LEN / 2;
    localparam int WBITS  = 2 * IN_LEN * OUT_LEN;
    localparam int WBYTES = (WBITS + 7) / 8;

    localparam logic [1:0] TW_ZERO = 2'b00;
    localparam logic [1:0] TW_POS  = 2'b01;
    localparam logic [1:0] TW_ZALT = 2'b10;
    localparam logic [1:0] TW_NEG  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_COMPUTE,
        ST_SETTLE,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/ternary_wbuf.sv
// Packs the weight byte stream into the flat matrix register; byte k lands at bits [8k +: 8].
// Latency: matrix updated on the accepting edge, w_loaded one cycle after the last byte. No backpressure of its own.
module ternary_wbuf #(
    parameter int Wbits  = 196,
    parameter int Wbytes = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [7:0]       w_byte,
    output logic [Wbits-1:0] w_mat,
    output logic             w_loaded,
    output logic             last_wr
);
    localparam int CntW = $clog2(Wbytes);
    localparam logic [CntW-1:0] LastCnt = CntW'(Wbytes - 1);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Wbits-1:0] mat_q, mat_d;
    logic             loaded_q, loaded_d;
    logic [Wbits-1:0] byte_mask, byte_data;

    always_comb begin
        cnt_d    = cnt_q;
        mat_d    = mat_q;
        loaded_d = loaded_q;
        // Shifting into a Wbits-wide vector drops the pad bits of the final byte.
        byte_mask = Wbits'(8'hFF) << {cnt_q, 3'b000};
        byte_data = Wbits'(w_byte) << {cnt_q, 3'b000};
        last_wr   = wr_en && (cnt_q == LastCnt);
        if (clr) begin
            cnt_d    = '0;
            loaded_d = 1'b0;
        end else if (wr_en) begin
            mat_d = (mat_q & ~byte_mask) | byte_data;
            if (last_wr) begin
                cnt_d    = '0;
                loaded_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            mat_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mat_q    <= mat_d;
            loaded_q <= loaded_d;
        end
    end

    assign w_mat    = mat_q;
    assign w_loaded = loaded_q;

endmodule

// File: rtl/ternary_mvm_seq.sv
// Sequencer for the ternary MVM datapath: weight load, row-by-row activation issue, result drain.
// Latency: ROWS accepted pairs + 1 settle cycle, then 2 cycles per result. x_valid/y_ready stalls hold all state.
// Optional stall counter enabled by TERNARY_STALL_CNT_EN.
module ternary_mvm_seq
    import ternary_mvm_pkg::*;
#(
    parameter int InLen    = IN_LEN,
    parameter int OutLen   = OUT_LEN,
    parameter int BitWidth = BIT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_w,
    input  logic                      w_valid,
    input  logic [7:0]                w_byte,
    output logic                      w_ready,
    input  logic                      start,
    input  logic                      x_valid,
    input  logic [2*BitWidth-1:0]     x_data,
    output logic                      x_ready,
    output logic [2:0]                mult_row,
    output logic [2*BitWidth-1:0]     mult_vec,
    output logic [2*InLen*OutLen-1:0] mult_w,
    input  logic [BitWidth-1:0]       mult_vecout,
    output logic                      y_valid,
    output logic [BitWidth-1:0]       y_data,
    input  logic                      y_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      w_loaded,
    output logic [15:0]               stall_cnt
);
    localparam int Wbits  = 2 * InLen * OutLen;
    localparam int Wbytes = (Wbits + 7) / 8;
    localparam logic [2:0] LastRow = 3'(InLen / 2 - 1);
    localparam logic [2:0] LastIdx = 3'(OutLen - 1);

    state_e                state_q, state_d;
    logic [2:0]            row_q, row_d;
    logic [2:0]            idx_q, idx_d;
    logic [2*BitWidth-1:0] vec_q, vec_d;
    logic [BitWidth-1:0]   y_data_q, y_data_d;
    logic                  y_vld_q, y_vld_d;
    logic                  w_clr, w_wr, w_last;

    ternary_wbuf #(
        .Wbits  (Wbits),
        .Wbytes (Wbytes)
    ) u_wbuf (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .wr_en    (w_wr),
        .w_byte   (w_byte),
        .w_mat    (mult_w),
        .w_loaded (w_loaded),
        .last_wr  (w_last)
    );

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        idx_d    = idx_q;
        vec_d    = vec_q;
        y_data_d = y_data_q;
        y_vld_d  = y_vld_q;
        w_clr    = 1'b0;
        w_wr     = 1'b0;
        w_ready  = 1'b0;
        x_ready  = 1'b0;
        mult_row = 3'd0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_w) begin
                    state_d = ST_LOAD_W;
                    w_clr   = 1'b1;
                end else if (start && w_loaded) begin
                    state_d = ST_COMPUTE;
                    row_d   = 3'd0;
                end
            end
            ST_LOAD_W: begin
                w_ready = 1'b1;
                w_wr    = w_valid;
                if (w_last) state_d = ST_IDLE;
            end
            ST_COMPUTE: begin
                x_ready  = 1'b1;
                mult_row = row_q;
                if (x_valid) begin
                    vec_d = x_data;
                    if (row_q == LastRow) begin
                        state_d = ST_SETTLE;
                        row_d   = 3'd0;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end
            end
            ST_SETTLE: begin
                state_d = ST_DRAIN;
                idx_d   = 3'd0;
                y_vld_d = 1'b0;
            end
            ST_DRAIN: begin
                mult_row = idx_q;
                // Capture the selected result, then hold it until the sink takes it.
                if (!y_vld_q) begin
                    y_data_d = mult_vecout;
                    y_vld_d  = 1'b1;
                end else if (y_ready) begin
                    y_vld_d = 1'b0;
                    if (idx_q == LastIdx) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            row_q    <= 3'd0;
            idx_q    <= 3'd0;
            vec_q    <= '0;
            y_data_q <= '0;
            y_vld_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            idx_q    <= idx_d;
            vec_q    <= vec_d;
            y_data_q <= y_data_d;
            y_vld_q  <= y_vld_d;
        end
    end

    assign mult_vec = vec_q;
    assign y_valid  = y_vld_q;
    assign y_data   = y_data_q;
    assign busy     = (state_q != ST_IDLE);

`ifdef TERNARY_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_IDLE && !load_w && start && w_loaded) begin
            stall_d = 16'd0;
        end else if (((state_q == ST_COMPUTE && !x_valid) ||
                      (state_q == ST_DRAIN && y_vld_q && !y_ready)) &&
                     stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= 16'd0;
        else     stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ternary_mvm_seq.sv
// Randomized bench for ternary_mvm_seq with a behavioural datapath stand-in and a matrix-product reference.
module tb_ternary_mvm_seq;
    localparam int IN     = 14;
    localparam int OUT    = 7;
    localparam int NROW   = IN / 2;
    localparam int WBYTES = 25;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  load_w, w_valid, w_ready;
    logic [7:0]            w_byte;
    logic                  start, x_valid, x_ready;
    logic [15:0]           x_data, mult_vec;
    logic [2:0]            mult_row;
    logic [2*IN*OUT-1:0]   mult_w;
    logic [7:0]            mult_vecout, y_data;
    logic                  y_valid, y_ready, busy, done, w_loaded;
    logic [15:0]           stall_cnt;

    always #5 clk = ~clk;

    ternary_mvm_seq dut (
        .clk         (clk),
        .rst         (rst),
        .load_w      (load_w),
        .w_valid     (w_valid),
        .w_byte      (w_byte),
        .w_ready     (w_ready),
        .start       (start),
        .x_valid     (x_valid),
        .x_data      (x_data),
        .x_ready     (x_ready),
        .mult_row    (mult_row),
        .mult_vec    (mult_vec),
        .mult_w      (mult_w),
        .mult_vecout (mult_vecout),
        .y_valid     (y_valid),
        .y_data      (y_data),
        .y_ready     (y_ready),
        .busy        (busy),
        .done        (done),
        .w_loaded    (w_loaded),
        .stall_cnt   (stall_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] wb[WBYTES];
    int         xs[IN];
    int         gap[NROW];
    int         hold[OUT];

    function automatic int tern(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    // Expected y[j] = sum_i w[j][i] * x[i], weight n = j*IN+i taken from the byte stream.
    function automatic logic [7:0] ref_y(input int j);
        int acc;
        int n;
        logic [7:0] b;
        acc = 0;
        for (int i = 0; i < IN; i++) begin
            n   = j * IN + i;
            b   = wb[n / 4];
            acc += tern(2'(b >> (2 * (n % 4)))) * xs[i];
        end
        return acc[7:0];
    endfunction

    function automatic logic [15:0] pack(input int r);
        return {8'(xs[2*r+1]), 8'(xs[2*r])};
    endfunction

    // Datapath stand-in: latches the pair one cycle after its row is accepted,
    // and presents output mult_row combinationally from the DUT's weight bus.
    int         acts[IN];
    logic       pend_vld = 1'b0;
    logic [2:0] pend_row = 3'd0;
    int         dp_r;
    int         dp_acc;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            pend_vld = 1'b0;
        end else begin
            if (pend_vld) begin
                dp_r              = int'(pend_row);
                acts[2*dp_r]      = int'($signed(mult_vec[7:0]));
                acts[2*dp_r + 1]  = int'($signed(mult_vec[15:8]));
            end
            pend_vld = x_valid && x_ready;
            pend_row = mult_row;
        end
    end

    always_comb begin
        dp_acc = 0;
        if (int'(mult_row) < OUT) begin
            for (int i = 0; i < IN; i++)
                dp_acc += tern(mult_w[2*(int'(mult_row)*IN + i) +: 2]) * acts[i];
        end
        mult_vecout = dp_acc[7:0];
    end

    int done_seen = 0;
    always @(negedge clk) begin
        #2;
        if (done === 1'b1) done_seen++;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load_weights(input bit conflict);
        int k;
        k = 0;
        cyc(); load_w = 1'b1; start = conflict; #1;
        for (int t = 0; t < 200 && k < WBYTES; t++) begin
            cyc();
            load_w  = 1'b0;
            start   = conflict ? 1'($urandom_range(0, 1)) : 1'b0;
            w_valid = ($urandom_range(0, 3) != 0);
            w_byte  = wb[k];
            #1;
            if (t == 0) begin
                check_eq("load_w_ready", w_ready, 1);
                check_eq("load_w_loaded_low", w_loaded, 0);
            end
            if (w_valid && w_ready) k++;
        end
        if (k < WBYTES) check_eq("load_budget", k, WBYTES);
        cyc(); w_valid = 1'b0; start = 1'b0; #1;
        check_eq("load_done_w_loaded", w_loaded, 1);
        check_eq("load_done_idle", busy, 0);
        check_eq("load_done_w_ready", w_ready, 0);
    endtask

    task automatic run_vec(input int abort_at, input bit started, input bit chain_next);
        int         exp_stall;
        int         d0;
        int         h;
        bit         found;
        logic [7:0] held;
        exp_stall = 0;
        d0        = done_seen;
        if (!started) begin
            cyc(); start = 1'b1; #1;
            check_eq("pre_start_idle", busy, 0);
        end
        for (int r = 0; r < NROW; r++) begin
            cyc(); start = 1'b0; x_valid = 1'b1; x_data = pack(r); #1;
            check_eq("x_ready", x_ready, 1);
            check_eq("mult_row", mult_row, r);
            if (r < NROW - 1) begin
                for (int g = 0; g < gap[r]; g++) begin
                    cyc(); x_valid = 1'b0; x_data = 16'($urandom); #1;
                    check_eq("gap_row_hold", mult_row, r + 1);
                    check_eq("gap_vec_hold", mult_vec, pack(r));
                    exp_stall++;
                end
            end
        end
        cyc(); x_valid = 1'b0; #1;
        check_eq("settle_row", mult_row, 0);
        check_eq("settle_busy", busy, 1);
        check_eq("settle_x_ready", x_ready, 0);
        check_eq("settle_vec", mult_vec, pack(NROW - 1));
        for (int j = 0; j < OUT; j++) begin
            h     = hold[j];
            found = 1'b0;
            for (int t = 0; t < 10 && !found; t++) begin
                cyc(); y_ready = (h == 0); #1;
                found = y_valid;
            end
            if (!found) begin
                check_eq("y_valid_timeout", y_valid, 1);
                return;
            end
            check_eq("y_data", y_data, ref_y(j));
            if (j == abort_at) begin
                rst = 1'b1; #1;
                check_eq("abort_busy", busy, 0);
                check_eq("abort_y_valid", y_valid, 0);
                check_eq("abort_w_loaded", w_loaded, 0);
                check_eq("abort_done", done, 0);
                cyc(); rst = 1'b0; y_ready = 1'b0; #1;
                check_eq("abort_idle", busy, 0);
                check_eq("abort_no_done", done_seen, d0);
                return;
            end
            held = y_data;
            if (h > 0) begin
                for (int s = 1; s < h; s++) begin
                    cyc(); y_ready = 1'b0; #1;
                    check_eq("hold_y_valid", y_valid, 1);
                    check_eq("hold_y_data", y_data, held);
                end
                cyc(); y_ready = 1'b1; #1;
                check_eq("accept_y_valid", y_valid, 1);
            end
            check_eq("done_pulse", done, (j == OUT - 1));
            exp_stall += h;
        end
        cyc(); y_ready = 1'b0; start = chain_next; #1;
        check_eq("post_idle", busy, 0);
        check_eq("post_done_low", done, 0);
        check_eq("done_count", done_seen, d0 + 1);
`ifdef TERNARY_STALL_CNT_EN
        check_eq("stall_cnt", stall_cnt, exp_stall);
`else
        check_eq("stall_cnt", stall_cnt, 0);
`endif
    endtask

    task automatic randomize_all(input int gmax, input int hmax);
        for (int i = 0; i < IN; i++)   xs[i]   = int'($urandom_range(0, 255)) - 128;
        for (int r = 0; r < NROW; r++) gap[r]  = int'($urandom_range(0, gmax));
        for (int j = 0; j < OUT; j++)  hold[j] = int'($urandom_range(0, hmax));
    endtask

    initial begin
        rst = 1'b1; load_w = 1'b0; w_valid = 1'b0; w_byte = 8'd0; start = 1'b0;
        x_valid = 1'b0; x_data = 16'd0; y_ready = 1'b0;
        repeat (2) cyc();
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_w_ready", w_ready, 0);
        check_eq("rst_x_ready", x_ready, 0);
        check_eq("rst_y_valid", y_valid, 0);
        check_eq("rst_y_data", y_data, 0);
        check_eq("rst_mult_row", mult_row, 0);
        check_eq("rst_mult_vec", mult_vec, 0);
        check_eq("rst_mult_w_zero", (mult_w == '0), 1);
        check_eq("rst_w_loaded", w_loaded, 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        cyc(); rst = 1'b0; #1;

        // start without a loaded matrix stays idle
        cyc(); start = 1'b1; #1;
        cyc(); start = 1'b0; #1;
        check_eq("noload_busy", busy, 0);
        check_eq("noload_x_ready", x_ready, 0);

        // all +1 weights, unit activations
        for (int k = 0; k < WBYTES; k++) wb[k] = 8'h55;
        for (int i = 0; i < IN; i++) xs[i] = 1;
        for (int r = 0; r < NROW; r++) gap[r] = 0;
        for (int j = 0; j < OUT; j++) hold[j] = 0;
        load_weights(1'b0);
        run_vec(-1, 1'b0, 1'b0);

        // all -1 weights, x_valid toggling
        for (int k = 0; k < WBYTES; k++) wb[k] = 8'hFF;
        for (int r = 0; r < NROW; r++) gap[r] = 1;
        load_weights(1'b0);
        run_vec(-1, 1'b0, 1'b0);

        // random weights, sink stalls 5 cycles at idx 2, then back-to-back start
        for (int k = 0; k < WBYTES; k++) wb[k] = 8'($urandom);
        randomize_all(0, 0);
        hold[2] = 5;
        load_weights(1'b0);
        run_vec(-1, 1'b0, 1'b1);
        randomize_all(2, 2);
        run_vec(-1, 1'b1, 1'b0);

        // load_w and start together, start noise during load
        for (int k = 0; k < WBYTES; k++) wb[k] = 8'($urandom);
        randomize_all(0, 0);
        load_weights(1'b1);
        run_vec(-1, 1'b0, 1'b0);

        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < WBYTES; k++) wb[k] = 8'($urandom);
            randomize_all(2, 3);
            load_weights(1'b0);
            run_vec(-1, 1'b0, 1'b0);
        end

        // reset while draining idx 3
        randomize_all(1, 0);
        run_vec(3, 1'b0, 1'b0);
        cyc(); start = 1'b1; #1;
        cyc(); start = 1'b0; #1;
        check_eq("post_abort_start_ignored", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
